// File: rtl/z88_ram_resp.sv
// ---------------------------------------------------------------------------
// z88_ram_resp
//   Asynchronous-style SRAM responder for a Z88-class bus. The initiator
//   frames each access with ram_ce_n; the control inputs are captured on
//   the first rising edge that sees ram_ce_n low while IDLE (the start edge),
//   and nothing further happens until ram_ce_n has been seen high again.
//
// Parameters
//   ADDR_W     : decoded word-address bits; upper ram_addr bits alias.
//
// Ports
//   clk        : system clock, rising-edge active
//   rst        : asynchronous active-high reset
//   ram_ce_n   : chip enable, active-low
//   ram_oe_n   : output enable / read request, active-low
//   ram_we_n   : write enable / write request, active-low
//   ram_be_n   : byte enables, active-low ([0] = bits 7:0, [1] = bits 15:8)
//   ram_addr   : word address
//   ram_wdata  : write data
//   ram_rdata  : registered read data, held until the next read start
//   busy       : high for the single cycle spent in ACCESS
//   err_cnt    : saturating count of starts with both oe_n and we_n low
//
// Optional feature (macro Z88_RAM_RESP_WPROT_EN)
//   wp         : write protect; a write start with wp=1 commits nothing
//   wp_err     : sticky flag set by a protected write, cleared by rst
// ---------------------------------------------------------------------------
module z88_ram_resp #(
    parameter int unsigned ADDR_W = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_ce_n,
    input  logic        ram_oe_n,
    input  logic        ram_we_n,
    input  logic [1:0]  ram_be_n,
    input  logic [18:0] ram_addr,
    input  logic [15:0] ram_wdata,
`ifdef Z88_RAM_RESP_WPROT_EN
    input  logic        wp,
    output logic        wp_err,
`endif
    output logic [15:0] ram_rdata,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HOLD
    } state_t;

    state_t state;

    // Two independent byte lanes; never reset so contents survive rst.
    logic [7:0] mem_lo [0:DEPTH-1];
    logic [7:0] mem_hi [0:DEPTH-1];

    logic              start;
    logic              wr_ok;
    logic              commit_lo;
    logic              commit_hi;
    logic [ADDR_W-1:0] idx;

    // Upper address bits are deliberately ignored so the array aliases.
    generate
        if (ADDR_W < 19) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^ram_addr[18:ADDR_W];
        end
    endgenerate

    always_comb begin
        idx   = ram_addr[ADDR_W-1:0];
        // Only IDLE may start: this is what enforces one transaction per
        // ram_ce_n low period, and HOLD out of reset blocks a start until
        // ram_ce_n has been sampled high.
        start = (state == IDLE) && !ram_ce_n;
`ifdef Z88_RAM_RESP_WPROT_EN
        wr_ok = !ram_we_n && !wp;
`else
        wr_ok = !ram_we_n;
`endif
        commit_lo = start && wr_ok && !ram_be_n[0];
        commit_hi = start && wr_ok && !ram_be_n[1];
    end

    always_ff @(posedge clk) begin
        if (commit_lo) begin
            mem_lo[idx] <= ram_wdata[7:0];
        end
        if (commit_hi) begin
            mem_hi[idx] <= ram_wdata[15:8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HOLD;
            ram_rdata <= '0;
            busy      <= 1'b0;
            err_cnt   <= '0;
`ifdef Z88_RAM_RESP_WPROT_EN
            wp_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!ram_ce_n) begin
                        state <= ACCESS;
                        busy  <= 1'b1;
                        // Read returns the whole word regardless of ram_be_n;
                        // the old contents are read before any same-edge write.
                        if (!ram_oe_n && ram_we_n) begin
                            ram_rdata <= {mem_hi[idx], mem_lo[idx]};
                        end
                        if (!ram_oe_n && !ram_we_n && (err_cnt != '1)) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
`ifdef Z88_RAM_RESP_WPROT_EN
                        if (!ram_we_n && wp) begin
                            wp_err <= 1'b1;
                        end
`endif
                    end
                end
                ACCESS: begin
                    busy  <= 1'b0;
                    state <= ram_ce_n ? IDLE : HOLD;
                end
                HOLD: begin
                    busy <= 1'b0;
                    if (ram_ce_n) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z88_ram_resp.sv
module tb_z88_ram_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic [1:0]  ram_be_n;
    logic [18:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        busy;
    logic [7:0]  err_cnt;
`ifdef Z88_RAM_RESP_WPROT_EN
    logic        wp;
    logic        wp_err;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    z88_ram_resp #(.ADDR_W(18)) dut (
        .clk       (clk),
        .rst       (rst),
        .ram_ce_n  (ram_ce_n),
        .ram_oe_n  (ram_oe_n),
        .ram_we_n  (ram_we_n),
        .ram_be_n  (ram_be_n),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
`ifdef Z88_RAM_RESP_WPROT_EN
        .wp        (wp),
        .wp_err    (wp_err),
`endif
        .ram_rdata (ram_rdata),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic oe_n, input logic we_n, input logic [1:0] be_n,
                         input logic [18:0] addr, input logic [15:0] wd);
        ram_ce_n  = 1'b0;
        ram_oe_n  = oe_n;
        ram_we_n  = we_n;
        ram_be_n  = be_n;
        ram_addr  = addr;
        ram_wdata = wd;
    endtask

    task automatic idle_bus();
        ram_ce_n = 1'b1;
        ram_oe_n = 1'b1;
        ram_we_n = 1'b1;
        ram_be_n = 2'b11;
    endtask

    // Start edge then one ce_n-high cycle: ends back in IDLE.
    task automatic xact(input logic oe_n, input logic we_n, input logic [1:0] be_n,
                        input logic [18:0] addr, input logic [15:0] wd);
        drive(oe_n, we_n, be_n, addr, wd);
        tick();
        idle_bus();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_bus();
        ram_addr  = '0;
        ram_wdata = '0;
`ifdef Z88_RAM_RESP_WPROT_EN
        wp = 1'b0;
`endif
        tick();
        tick();
        check("rst_rdata", ram_rdata, 16'h0000);
        check("rst_busy",  {15'd0, busy}, 16'd0);
        check("rst_err",   {8'd0, err_cnt}, 16'd0);
        rst = 1'b0;
        tick();                             // HOLD -> IDLE (ce_n high)

        // Basic write / read-back, busy exactly one cycle.
        xact(1'b1, 1'b0, 2'b00, 19'h00123, 16'hBEEF);
        check("wr_no_rdata", ram_rdata, 16'h0000);
        drive(1'b0, 1'b1, 2'b11, 19'h00123, 16'h0000);
        tick();
        check("rd_beef", ram_rdata, 16'hBEEF);
        check("rd_busy1", {15'd0, busy}, 16'd1);
        idle_bus();
        tick();
        check("rd_busy0", {15'd0, busy}, 16'd0);

        // Byte-lane merge.
        xact(1'b1, 1'b0, 2'b00, 19'h00010, 16'h1111);
        xact(1'b1, 1'b0, 2'b10, 19'h00010, 16'hAA22);
        xact(1'b0, 1'b1, 2'b00, 19'h00010, 16'h0000);
        check("merge_lo", ram_rdata, 16'h1122);
        xact(1'b1, 1'b0, 2'b01, 19'h00010, 16'h33BB);
        xact(1'b0, 1'b1, 2'b01, 19'h00010, 16'h0000);
        check("merge_hi", ram_rdata, 16'h3322);

        // be_n=11 writes nothing; address aliasing above ADDR_W.
        xact(1'b1, 1'b0, 2'b00, 19'h00020, 16'h7777);
        xact(1'b1, 1'b0, 2'b11, 19'h00020, 16'hFFFF);
        xact(1'b0, 1'b1, 2'b00, 19'h00020, 16'h0000);
        check("be11_nowrite", ram_rdata, 16'h7777);
        xact(1'b0, 1'b1, 2'b00, 19'h40123, 16'h0000);
        check("alias_rd", ram_rdata, 16'hBEEF);

        // No-op start still enters ACCESS and leaves ram_rdata alone.
        drive(1'b1, 1'b1, 2'b00, 19'h00010, 16'h0000);
        tick();
        check("noop_busy", {15'd0, busy}, 16'd1);
        check("noop_rdata", ram_rdata, 16'hBEEF);
        idle_bus();
        tick();

        // Long ce_n low period: one read only, later changes ignored.
        drive(1'b0, 1'b1, 2'b00, 19'h00010, 16'h0000);
        tick();
        check("long_busy_first", {15'd0, busy}, 16'd1);
        check("long_rdata", ram_rdata, 16'h3322);
        ram_addr = 19'h00020;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("long_hold_busy", {15'd0, busy}, 16'd0);
            check("long_hold_rdata", ram_rdata, 16'h3322);
        end
        idle_bus();
        tick();
        check("long_end_busy", {15'd0, busy}, 16'd0);

        // Back-to-back with one-cycle gap.
        xact(1'b1, 1'b0, 2'b00, 19'h00040, 16'h1234);
        xact(1'b0, 1'b1, 2'b00, 19'h00040, 16'h0000);
        check("b2b_rd", ram_rdata, 16'h1234);

        // Protocol errors: writes still commit, count saturates.
        for (int i = 0; i < 300; i++) begin
            xact(1'b0, 1'b0, 2'b00, 19'h00030, 16'(i));
            if (i == 0) check("err_first", {8'd0, err_cnt}, 16'd1);
        end
        check("err_rdata", ram_rdata, 16'h1234);
        check("err_sat", {8'd0, err_cnt}, 16'd255);
        xact(1'b0, 1'b1, 2'b00, 19'h00030, 16'h0000);
        check("err_wr_commit", ram_rdata, 16'h012B);

        // Reset during HOLD, released with ce_n still low.
        drive(1'b0, 1'b1, 2'b00, 19'h00123, 16'h0000);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_rdata", ram_rdata, 16'h0000);
        check("mid_rst_busy", {15'd0, busy}, 16'd0);
        check("mid_rst_err", {8'd0, err_cnt}, 16'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_nostart", {15'd0, busy}, 16'd0);
        end
        check("post_rst_rdata", ram_rdata, 16'h0000);
        idle_bus();
        tick();
        drive(1'b0, 1'b1, 2'b00, 19'h00123, 16'h0000);
        tick();
        check("post_rst_busy", {15'd0, busy}, 16'd1);
        check("post_rst_retain", ram_rdata, 16'hBEEF);
        idle_bus();
        tick();

`ifdef Z88_RAM_RESP_WPROT_EN
        check("wp_err_init", {15'd0, wp_err}, 16'd0);
        wp = 1'b1;
        drive(1'b1, 1'b0, 2'b00, 19'h00123, 16'h5555);
        tick();
        check("wp_busy", {15'd0, busy}, 16'd1);
        idle_bus();
        tick();
        wp = 1'b0;
        xact(1'b0, 1'b1, 2'b00, 19'h00123, 16'h0000);
        check("wp_nowrite", ram_rdata, 16'hBEEF);
        check("wp_err_set", {15'd0, wp_err}, 16'd1);
        xact(1'b1, 1'b0, 2'b00, 19'h00050, 16'h4321);
        check("wp_err_sticky", {15'd0, wp_err}, 16'd1);
        rst = 1'b1;
        tick();
        check("wp_err_rst", {15'd0, wp_err}, 16'd0);
        rst = 1'b0;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
